// File: rtl/mac_out_collector.sv
// ---------------------------------------------------------------------------
// mac_out_collector
//
// Receiving end of the MAC array's south-side psum interface. Each column
// has its own FIFO that captures a psum whenever that column's valid bit is
// high. Once every FIFO holds at least one entry, the heads pop together
// and form one aligned output row. Column skew of any size up to the FIFO
// depth is absorbed this way. This works for both WS (skewed last-row valids)
// and OS (OR-merged flush valids) operation, because only the per-column
// valid bits are used.
//
// Rows are presented through a single valid/ready register stage. An
// optional ReLU is applied at load time.
//
// Ports
//   clk        rising-edge clock for all state
//   reset      asynchronous active-low reset
//   in_psum    packed psums, column j at [psum_bw*(j+1)-1 : psum_bw*j]
//   in_valid   per-column push qualifier
//   clear      synchronous flush of all buffered state (out_data kept)
//   relu_en    clamp negative psums to zero when a row is loaded
//   out_data   aligned output row, same packing as in_psum
//   out_valid  out_data holds a row
//   out_ready  consumer accepts the row when out_valid & out_ready
//   col_full   bit j: FIFO j holds depth entries
//   all_empty  every FIFO empty and no row held in the output stage
//   ovf        sticky per-column flag: a psum was dropped on a full FIFO
// ---------------------------------------------------------------------------
module mac_out_collector #(
  parameter int unsigned col     = 8,
  parameter int unsigned psum_bw = 16,
  parameter int unsigned depth   = 16,
  parameter int unsigned cnt_bw  = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [psum_bw*col-1:0] in_psum,
  input  logic [col-1:0]         in_valid,
  input  logic                   clear,
  input  logic                   relu_en,
  output logic [psum_bw*col-1:0] out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [col-1:0]         col_full,
  output logic                   all_empty,
  output logic [col-1:0]         ovf
);

  localparam int unsigned PTR_BW = $clog2(depth);
  localparam logic [cnt_bw-1:0] FULL_CNT = cnt_bw'(depth);

  // Shared control
  logic                   w_row_avail;
  logic                   w_pop;
  logic [col-1:0]         w_full;
  logic [col-1:0]         w_nonempty;
  logic [col-1:0]         w_push;
  logic [col-1:0]         w_drop;
  logic [psum_bw*col-1:0] w_load_row;

  // Output register stage
  logic                   r_out_valid;
  logic [psum_bw*col-1:0] r_out_data;

  // A row can be formed only when every column has at least one entry.
  // It is loaded when the output stage is empty or is being drained in the
  // same cycle.
  assign w_row_avail = &w_nonempty;
  assign w_pop       = w_row_avail & (~r_out_valid | out_ready);

  // -------------------------------------------------------------------------
  // Per-column FIFOs
  // -------------------------------------------------------------------------
  for (genvar g = 0; g < col; g++) begin : g_col
    logic [psum_bw-1:0] r_mem [depth];
    logic [PTR_BW-1:0]  r_wr_ptr;
    logic [PTR_BW-1:0]  r_rd_ptr;
    logic [cnt_bw-1:0]  r_count;
    logic               r_ovf;
    logic [psum_bw-1:0] w_head;
    logic [psum_bw-1:0] w_head_relu;

    assign w_full[g]     = (r_count == FULL_CNT);
    assign w_nonempty[g] = (r_count != '0);

    // A full column still accepts a push when the heads pop at the same
    // edge: the slot being written is the one being vacated.
    assign w_push[g] = in_valid[g] & (~w_full[g] | w_pop);
    assign w_drop[g] = in_valid[g] & w_full[g] & ~w_pop;

    assign w_head = r_mem[r_rd_ptr];

    always_comb begin
      w_head_relu = w_head;
      if (relu_en && w_head[psum_bw-1]) begin
        w_head_relu = '0;
      end
    end

    assign w_load_row[g*psum_bw +: psum_bw] = w_head_relu;
    assign ovf[g] = r_ovf;

    // Storage has no reset. Stale contents become unreachable once the
    // pointers are cleared.
    always_ff @(posedge clk) begin
      if (w_push[g] && !clear) begin
        r_mem[r_wr_ptr] <= in_psum[g*psum_bw +: psum_bw];
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
        r_ovf    <= 1'b0;
      end else if (clear) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
        r_ovf    <= 1'b0;
      end else begin
        if (w_push[g]) begin
          r_wr_ptr <= r_wr_ptr + PTR_BW'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + PTR_BW'(1);
        end
        if (w_push[g] && !w_pop) begin
          r_count <= r_count + cnt_bw'(1);
        end else if (!w_push[g] && w_pop) begin
          r_count <= r_count - cnt_bw'(1);
        end
        if (w_drop[g]) begin
          r_ovf <= 1'b1;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Output stage
  // -------------------------------------------------------------------------
  // clear drops the held row but keeps out_data.
  // A drain without a reload also leaves out_data untouched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (clear) begin
      r_out_valid <= 1'b0;
    end else if (w_pop) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_load_row;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign col_full  = w_full;
  assign all_empty = (w_nonempty == '0) & ~r_out_valid;

endmodule

// File: tb/tb_mac_out_collector.sv
module tb_mac_out_collector;

  localparam int COL   = 8;
  localparam int BW    = 16;
  localparam int DEPTH = 16;

  logic                clk;
  logic                reset;
  logic [BW*COL-1:0]   in_psum;
  logic [COL-1:0]      in_valid;
  logic                clear;
  logic                relu_en;
  logic [BW*COL-1:0]   out_data;
  logic                out_valid;
  logic                out_ready;
  logic [COL-1:0]      col_full;
  logic                all_empty;
  logic [COL-1:0]      ovf;

  mac_out_collector #(
    .col(COL), .psum_bw(BW), .depth(DEPTH), .cnt_bw(5)
  ) dut (
    .clk(clk), .reset(reset), .in_psum(in_psum), .in_valid(in_valid),
    .clear(clear), .relu_en(relu_en), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .col_full(col_full),
    .all_empty(all_empty), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: one queue per column plus the output register.
  logic [BW-1:0]     mq [COL][$];
  logic              m_valid;
  logic [BW*COL-1:0] m_data;
  logic [COL-1:0]    m_ovf;

  task automatic chk(input string name, input logic [BW*COL-1:0] act,
                     input logic [BW*COL-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int j = 0; j < COL; j++) mq[j].delete();
    m_valid = 1'b0;
    m_data  = '0;
    m_ovf   = '0;
  endtask

  task automatic model_step(input logic [COL-1:0] v, input logic [BW*COL-1:0] p,
                            input logic relu, input logic rdy, input logic clr);
    bit avail, pop;
    logic [BW-1:0] x;
    if (clr) begin
      for (int j = 0; j < COL; j++) mq[j].delete();
      m_valid = 1'b0;
      m_ovf   = '0;
      return;
    end
    avail = 1;
    for (int j = 0; j < COL; j++) if (mq[j].size() == 0) avail = 0;
    pop = avail && (!m_valid || rdy);
    if (pop) begin
      for (int j = 0; j < COL; j++) begin
        x = mq[j].pop_front();
        if (relu && x[BW-1]) x = '0;
        m_data[j*BW +: BW] = x;
      end
      m_valid = 1'b1;
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
    // Pop happens first, so a full column being popped has room again.
    for (int j = 0; j < COL; j++) begin
      if (v[j]) begin
        if (mq[j].size() < DEPTH) mq[j].push_back(p[j*BW +: BW]);
        else m_ovf[j] = 1'b1;
      end
    end
  endtask

  task automatic check_model();
    logic [COL-1:0] ef;
    bit em;
    em = !m_valid;
    for (int j = 0; j < COL; j++) begin
      ef[j] = (mq[j].size() == DEPTH);
      if (mq[j].size() != 0) em = 0;
    end
    chk("out_valid", {127'd0, out_valid}, {127'd0, m_valid});
    chk("out_data", out_data, m_data);
    chk("col_full", {120'd0, col_full}, {120'd0, ef});
    chk("all_empty", {127'd0, all_empty}, {127'd0, em});
    chk("ovf", {120'd0, ovf}, {120'd0, m_ovf});
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(in_valid, in_psum, relu_en, out_ready, clear);
    #1;
    check_model();
  endtask

  typedef struct {
    logic [COL-1:0]    v;
    logic [BW*COL-1:0] psum;
    logic              relu;
    logic              rdy;
    logic              exp_valid;
    logic [BW*COL-1:0] exp_data;
    logic              exp_empty;
  } vec_t;

  vec_t tbl [8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [BW*COL-1:0] row_a, row_b, row_b_relu, row;
    int first_valid, rows_out;

    // Construct the table rows.
    for (int j = 0; j < COL; j++) begin
      row_a[j*BW +: BW]      = BW'(j + 1);
      row_b[j*BW +: BW]      = BW'(16'h0100 + j);
      row_b_relu[j*BW +: BW] = BW'(16'h0100 + j);
    end
    row_b[0 +: BW]       = 16'hFFF6;
    row_b[BW +: BW]      = 16'h000A;
    row_b[7*BW +: BW]    = 16'h8000;
    row_b_relu[0 +: BW]  = 16'h0000;
    row_b_relu[BW +: BW] = 16'h000A;
    row_b_relu[7*BW +: BW] = 16'h0000;
    tbl[0] = '{8'hFF, row_a, 1'b0, 1'b1, 1'b0, '0,         1'b0};
    tbl[1] = '{8'h00, '0,    1'b0, 1'b1, 1'b1, row_a,      1'b0};
    tbl[2] = '{8'h00, '0,    1'b0, 1'b1, 1'b0, row_a,      1'b1};
    tbl[3] = '{8'hFF, row_b, 1'b0, 1'b1, 1'b0, row_a,      1'b0};
    tbl[4] = '{8'h00, '0,    1'b1, 1'b1, 1'b1, row_b_relu, 1'b0};
    tbl[5] = '{8'hFF, row_b, 1'b0, 1'b0, 1'b1, row_b_relu, 1'b0};
    tbl[6] = '{8'h00, '0,    1'b0, 1'b1, 1'b1, row_b,      1'b0};
    tbl[7] = '{8'h00, '0,    1'b0, 1'b1, 1'b0, row_b,      1'b1};

    // Reset state.
    reset = 1'b0; in_psum = '0; in_valid = '0; clear = 1'b0;
    relu_en = 1'b0; out_ready = 1'b0;
    model_reset();
    #3;
    check_model();
    #9 reset = 1'b1;

    // Table: aligned write, drain, and ReLU on/off.
    foreach (tbl[i]) begin
      in_valid = tbl[i].v; in_psum = tbl[i].psum;
      relu_en = tbl[i].relu; out_ready = tbl[i].rdy;
      tick();
      chk($sformatf("tbl%0d_valid", i), {127'd0, out_valid}, {127'd0, tbl[i].exp_valid});
      chk($sformatf("tbl%0d_data", i), out_data, tbl[i].exp_data);
      chk($sformatf("tbl%0d_empty", i), {127'd0, all_empty}, {127'd0, tbl[i].exp_empty});
    end
    relu_en = 1'b0;

    // WS skew: column j sees row r at cycle j+r.
    first_valid = -1; rows_out = 0; out_ready = 1'b1;
    for (int t = 0; t < 13; t++) begin
      in_valid = '0; in_psum = '0;
      for (int j = 0; j < COL; j++) begin
        if (t - j >= 0 && t - j < 3) begin
          in_valid[j] = 1'b1;
          in_psum[j*BW +: BW] = BW'(100 + j + 16 * (t - j));
        end
      end
      tick();
      if (out_valid) begin
        if (first_valid < 0) begin
          first_valid = t;
          for (int j = 0; j < COL; j++) row[j*BW +: BW] = BW'(100 + j);
          chk("ws_first_row", out_data, row);
        end
        rows_out++;
      end
    end
    in_valid = '0;
    chk("ws_first_cycle", 128'(first_valid), 128'd8);
    chk("ws_rows_out", 128'(rows_out), 128'd3);
    chk("ws_ovf", {120'd0, ovf}, '0);

    // Backpressure and overflow on column 0.
    out_ready = 1'b0;
    for (int k = 0; k < 17; k++) begin
      in_valid = 8'h01; in_psum = '0; in_psum[0 +: BW] = BW'(1000 + k);
      tick();
      if (k == 15) begin
        chk("bp_full16", {120'd0, col_full}, 128'h01);
        chk("bp_noovf16", {120'd0, ovf}, '0);
      end
    end
    chk("bp_ovf17", {120'd0, ovf}, 128'h01);
    for (int j = 0; j < COL; j++) in_psum[j*BW +: BW] = BW'(2000 + j);
    in_valid = 8'hFF;
    tick();
    in_valid = '0;
    tick();
    row[0 +: BW] = BW'(1000);
    for (int j = 1; j < COL; j++) row[j*BW +: BW] = BW'(2000 + j);
    chk("bp_first_valid", {127'd0, out_valid}, 128'd1);
    chk("bp_first_row", out_data, row);
    out_ready = 1'b1;
    tick();

    // Clear mid-stream with rows buffered and ovf set.
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      in_valid = 8'hFF; in_psum = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end
    in_valid = '0; clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_valid", {127'd0, out_valid}, '0);
    chk("clr_empty", {127'd0, all_empty}, 128'd1);
    chk("clr_ovf", {120'd0, ovf}, '0);

    // Fill every column to depth, then push while popping.
    for (int k = 0; k < 17; k++) begin
      in_valid = 8'hFF;
      for (int j = 0; j < COL; j++) in_psum[j*BW +: BW] = BW'(3000 + 16 * k + j);
      tick();
    end
    chk("fp_all_full", {120'd0, col_full}, 128'hFF);
    out_ready = 1'b1;
    for (int k = 17; k < 20; k++) begin
      for (int j = 0; j < COL; j++) in_psum[j*BW +: BW] = BW'(3000 + 16 * k + j);
      tick();
      chk("fp_still_full", {120'd0, col_full}, 128'hFF);
      chk("fp_no_ovf", {120'd0, ovf}, '0);
    end
    in_valid = '0;
    for (int k = 0; k < 20; k++) tick();
    chk("fp_drained", {127'd0, all_empty}, 128'd1);

    // Async reset asserted between edges.
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 8'hFF; in_psum = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end
    in_valid = '0;
    #2 reset = 1'b0;
    #1;
    model_reset();
    chk("ar_valid", {127'd0, out_valid}, '0);
    chk("ar_data", out_data, '0);
    chk("ar_empty", {127'd0, all_empty}, 128'd1);
    chk("ar_full", {120'd0, col_full}, '0);
    #2 reset = 1'b1;

    // Randomized traffic against the model.
    for (int k = 0; k < 600; k++) begin
      in_valid  = ($urandom_range(0, 1) == 0) ? 8'hFF : COL'($urandom);
      in_psum   = {$urandom, $urandom, $urandom, $urandom};
      relu_en   = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      clear     = ($urandom_range(0, 63) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
